// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: inverse S-box, GF(2^8) helpers, sizes and FSM states.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE_PRE,
        ST_DONE
    } aes_state_e;

    // Entry for input byte b lives at bits [(255-b)*8 +: 8].
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return INV_SBOX_TBL[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless final_i is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_i,
    input  logic [AES_BLK_W-1:0] rk_i,
    input  logic                 final_i,
    output logic [AES_BLK_W-1:0] state_o
);

    logic [7:0] in_b  [16];
    logic [7:0] key_b [16];
    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            in_b[n]  = state_i[127-8*n -: 8];
            key_b[n] = rk_i[127-8*n -: 8];
        end
        // Byte (row r, col c) sits at index 4c+r; row r rotates right by r on decrypt.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark_b[4*c+r] = inv_sbox(in_b[4*((c - r + 4) % 4) + r]) ^ key_b[4*c+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c+0] = gmul14(ark_b[4*c+0]) ^ gmul11(ark_b[4*c+1])
                         ^ gmul13(ark_b[4*c+2]) ^ gmul9(ark_b[4*c+3]);
            mix_b[4*c+1] = gmul9(ark_b[4*c+0])  ^ gmul14(ark_b[4*c+1])
                         ^ gmul11(ark_b[4*c+2]) ^ gmul13(ark_b[4*c+3]);
            mix_b[4*c+2] = gmul13(ark_b[4*c+0]) ^ gmul9(ark_b[4*c+1])
                         ^ gmul14(ark_b[4*c+2]) ^ gmul11(ark_b[4*c+3]);
            mix_b[4*c+3] = gmul11(ark_b[4*c+0]) ^ gmul13(ark_b[4*c+1])
                         ^ gmul9(ark_b[4*c+2])  ^ gmul14(ark_b[4*c+3]);
        end
        state_o = '0;
        for (int n = 0; n < 16; n++) begin
            state_o[127-8*n -: 8] = final_i ? ark_b[n] : mix_b[n];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core, one block in flight, round keys fetched by index.
// AES_INV_OUT_REG_EN: drive plaintext/out_valid from a dedicated output register (one extra cycle).
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    // Both ports transfer on a rising edge where valid && ready; a producer holds its
    // payload steady while valid is high and not yet accepted.
    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] round_out;
    logic         final_rnd;

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk),
        .final_i (final_rnd),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rk_idx    = 4'(AES_NR);
        in_ready  = 1'b0;
        final_rnd = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = rst;
                if (in_valid && rst) begin
                    state_d = ciphertext ^ rk;
                    cnt_d   = 4'(AES_NR - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_idx  = cnt_q;
                state_d = round_out;
                if (cnt_q == 4'd1) begin
                    fsm_d = ST_FINAL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FINAL: begin
                rk_idx    = 4'd0;
                final_rnd = 1'b1;
                state_d   = round_out;
`ifdef AES_INV_OUT_REG_EN
                fsm_d     = ST_DONE_PRE;
`else
                fsm_d     = ST_DONE;
`endif
            end
            ST_DONE_PRE: begin
                fsm_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

`ifdef AES_INV_OUT_REG_EN
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (fsm_q == ST_DONE_PRE) begin
            out_d       = state_q;
            out_valid_d = 1'b1;
        end else if (fsm_q == ST_DONE && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign plaintext = out_q;
    assign out_valid = out_valid_q;
`else
    assign plaintext = state_q;
    assign out_valid = (fsm_q == ST_DONE);
`endif

endmodule
